pwm_modulator: RTL and testbench

- Output stage of the lab waveform generator. Consumes the signed-free 8-bit amplitude samples from the function/frequency generator core and converts them to the single-bit `out` line.
- The bit is pulse-width modulated and drives the board LED/filter.
- Applies `amp_sel` attenuation at period boundaries.
- Uses a one-deep sample holding register with a valid/ready handshake, so the upstream generator can run ahead by one sample.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_period_counter.sv | 36 +++
 rtl/pwm_modulator.sv | 161 ++++++++++++++++
 tb/tb_pwm_modulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared types and helpers for the PWM output stage.
//   - pwm_state_t : modulator FSM state encoding
//   - PWM_CNT_W   : default period counter width (period = 2^PWM_CNT_W clocks)
//   - scale()     : amplitude attenuation, sample >> amp_sel
package pwm_pkg;

  localparam int PWM_CNT_W   = 8;
  localparam int PWM_SCALE_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  // Operates on a wide container so any DATA_W up to 32 bits can use it;
  // callers truncate back to their own width.
  function automatic logic [PWM_SCALE_W-1:0] scale(
    input logic [PWM_SCALE_W-1:0] sample,
    input logic [1:0]             amp_sel
  );
    return sample >> amp_sel;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter
//   Free-running PWM period counter. Counts up while run is high and wraps
//   from 2^CNT_W-1 to 0; held at 0 while run is low.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset
//   run   in   count enable (modulator in RUN)
//   cnt   out  current position within the period
//   wrap  out  last cycle of the period (cnt at max while running)
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign wrap = run && (cnt == CNT_MAX);

endmodule

// File: rtl/pwm_modulator.sv
// pwm_modulator
//   PWM output stage of the waveform generator. Takes unsigned amplitude
//   samples through a one-deep holding register (valid/ready) and produces a
//   single modulated bit with duty = sample >> amp_sel, latched once per
//   period.
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   en            in   run request
//   sample_in     in   [DATA_W] unsigned sample
//   sample_valid  in   sample_in valid
//   sample_ready  out  holding register empty
//   amp_sel       in   [2] attenuation shift, sampled at period start
//   pwm_out       out  modulated output bit
//   period_done   out  one-cycle pulse after each completed period
//   underrun      out  one-cycle pulse when a period starts without a new sample
//   underrun_cnt  out  [8] saturating underrun count (only with PWM_UNDERRUN_CNT_EN)
// Build option:
//   PWM_UNDERRUN_CNT_EN  adds the underrun_cnt port and its counter.
//
// State table:
//   IDLE | stopped; counter held at 0, pwm_out low, hold register still accepts
//   RUN  | periods running; on the wrap edge stay (en=1, reload duty) or stop
module pwm_modulator
  import pwm_pkg::*;
#(
  parameter int CNT_W  = PWM_CNT_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [1:0]        amp_sel,
  output logic              pwm_out,
  output logic              period_done,
  output logic              underrun
`ifdef PWM_UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt
`endif
);

  if (DATA_W != CNT_W) begin : g_width_check
    $error("pwm_modulator: DATA_W must equal CNT_W");
  end

  pwm_state_t        state;
  pwm_state_t        state_nxt;
  logic              start;
  logic              load;
  logic              accept;
  logic              underrun_evt;
  logic [CNT_W-1:0]  cnt;
  logic              wrap;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] duty;

  pwm_period_counter #(
    .CNT_W (CNT_W)
  ) u_period_counter (
    .clk  (clk),
    .rst  (rst),
    .run  (state == RUN),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // load marks every period start: the IDLE->RUN edge and any wrap that
  // continues running. The final wrap into IDLE starts nothing, so it neither
  // consumes the hold register nor reports an underrun.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          start     = 1'b1;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          if (en) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign sample_ready = ~hold_full;
  assign accept       = sample_valid && sample_ready;
  assign underrun_evt = load && !hold_full;

  // accept and consume are mutually exclusive: ready is low whenever the
  // register holds something to consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= sample_in;
      hold_full <= 1'b1;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty <= '0;
    end else if (load && hold_full) begin
      duty <= DATA_W'(scale(PWM_SCALE_W'(hold), amp_sel));
    end
  end

  // Compare uses pre-edge cnt/duty, so the first high cycle follows the
  // load edge and exactly duty cycles are high per period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pwm_out     <= (state == RUN) && (cnt < duty);
      period_done <= wrap;
      underrun    <= underrun_evt;
    end
  end

`ifdef PWM_UNDERRUN_CNT_EN
  // A run that starts without a sample counts that first underrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= 8'd0;
    end else if (start) begin
      underrun_cnt <= underrun_evt ? 8'd1 : 8'd0;
    end else if (underrun_evt && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_modulator.sv
// tb_pwm_modulator
//   Randomized bench for pwm_modulator. A period-level reference model keeps
//   pending samples in a queue, decides when periods begin and end, and
//   predicts each output from "cycle k of a period is high iff k < duty".
//   Also checks the high-cycle total of every completed period.
module tb_pwm_modulator;

  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic [1:0] amp_sel = 2'd0;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_done;
  logic       underrun;
`ifdef PWM_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  pwm_modulator #(
    .CNT_W  (8),
    .DATA_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .amp_sel      (amp_sel),
    .pwm_out      (pwm_out),
    .period_done  (period_done),
    .underrun     (underrun)
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int          cyc;          // clock edges since reset release
  bit          m_active;     // a period is in progress
  int          m_start;      // edge on which the current period began
  int unsigned m_duty;       // high cycles per period currently in force
  int unsigned m_q[$];       // samples accepted but not yet used
  int unsigned m_uc;         // expected underrun count
  int unsigned m_highs;      // observed highs in the current period
  bit          m_accepted;   // set when the model sees a handshake
  int          m_phase_now;  // position in the period after the last edge

  task automatic model_reset();
    cyc         = 0;
    m_active    = 1'b0;
    m_start     = 0;
    m_duty      = 0;
    m_q.delete();
    m_uc        = 0;
    m_highs     = 0;
    m_phase_now = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pwm"}, 32'(pwm_out), 32'd0);
    check_eq({tag, "_done"}, 32'(period_done), 32'd0);
    check_eq({tag, "_underrun"}, 32'(underrun), 32'd0);
    check_eq({tag, "_ready"}, 32'(sample_ready), 32'd1);
`ifdef PWM_UNDERRUN_CNT_EN
    check_eq({tag, "_ucnt"}, 32'(underrun_cnt), 32'd0);
`endif
  endtask

  // Advance one clock: model the edge that just happened using the inputs
  // that were applied before it, then compare the DUT outputs.
  task automatic tick();
    int  ph;
    bit  exp_pwm, done, acc, first, load, exp_und;
    @(negedge clk);
    if (!rst) begin
      model_reset();
      check_reset_outputs("in_reset");
      return;
    end
    cyc++;
    ph      = cyc - m_start - 1;
    exp_pwm = m_active && (ph < int'(m_duty));
    done    = m_active && (ph == PERIOD - 1);
    acc     = sample_valid && (m_q.size() == 0);
    first   = !m_active && en;
    load    = first || (done && en);
    exp_und = 1'b0;

    if (m_active) m_highs += (pwm_out === 1'b1) ? 1 : 0;
    if (done) begin
      check_eq("period_highs", m_highs, m_duty);
      m_highs = 0;
    end
    if (load) begin
      if (m_q.size() > 0) m_duty = m_q.pop_front() >> amp_sel;
      else exp_und = 1'b1;
      m_start  = cyc;
      m_active = 1'b1;
      if (first) m_uc = exp_und ? 1 : 0;
      else if (exp_und && m_uc < 255) m_uc++;
    end else if (done) begin
      m_active = 1'b0;
    end
    if (acc) begin
      m_q.push_back(int'(sample_in));
      m_accepted = 1'b1;
    end
    m_phase_now = m_active ? (cyc - m_start) : 0;

    check_eq("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check_eq("period_done", 32'(period_done), 32'(done));
    check_eq("underrun", 32'(underrun), 32'(exp_und));
    check_eq("sample_ready", 32'(sample_ready), 32'(m_q.size() == 0));
`ifdef PWM_UNDERRUN_CNT_EN
    check_eq("underrun_cnt", 32'(underrun_cnt), m_uc);
`endif
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed_one(input logic [7:0] data);
    int budget;
    m_accepted   = 1'b0;
    sample_valid = 1'b1;
    sample_in    = data;
    budget       = 3 * PERIOD;
    while (!m_accepted && budget > 0) begin
      tick();
      budget--;
    end
    if (!m_accepted) check_eq("feed_timeout", 32'd0, 32'd1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int budget;
    budget = 3 * PERIOD;
    tick();
    while (!(m_active && m_phase_now == p) && budget > 0) begin
      tick();
      budget--;
    end
    if (!(m_active && m_phase_now == p)) check_eq("phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1;
    check_reset_outputs("reset");
    run_cycles(3);
    rst = 1'b1;
    run_cycles(5);

    // Basic duty with continuous backpressure on 0x80.
    amp_sel = 2'd0;
    feed_one(8'h80);
    en           = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 8'h80;
    run_cycles(3 * PERIOD + 4);

    // Attenuation: 0x80 >> 1, then 0xFF >> 3.
    amp_sel = 2'd1;
    run_cycles(PERIOD);
    sample_in = 8'hFF;
    amp_sel   = 2'd3;
    run_cycles(3 * PERIOD);

    // amp_sel change mid-period only affects the next period.
    wait_phase(100);
    amp_sel = 2'd0;
    run_cycles(2 * PERIOD);

    // Underrun: drain, then a single 0x40 sample followed by silence.
    sample_valid = 1'b0;
    run_cycles(2 * PERIOD + 10);
    feed_one(8'h40);
    run_cycles(3 * PERIOD);

    // Disable at cnt=10 with duty 200; hold survives IDLE.
    feed_one(8'd200);
    wait_phase(0);
    wait_phase(10);
    en = 1'b0;
    run_cycles(PERIOD + 40);
    feed_one(8'h30);
    run_cycles(20);
    en = 1'b1;
    run_cycles(PERIOD + 20);

    // Randomized traffic.
    for (int i = 0; i < 7000; i++) begin
      sample_valid = ($urandom_range(3) == 0);
      sample_in    = 8'($urandom);
      if ($urandom_range(399) == 0) amp_sel = 2'($urandom);
      if ($urandom_range(1499) == 0) en = ~en;
      tick();
    end

    // Asynchronous reset mid-period with the hold register full.
    en           = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 8'($urandom);
    wait_phase(50);
    wait_phase(60);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sample_valid = 1'b0;
    en           = 1'b0;
    run_cycles(3);
    rst = 1'b1;
    run_cycles(20);
    en = 1'b1;
    run_cycles(PERIOD + 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
